// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial LSB-first N-bit subtractor with adder-style flags
module serial_subtractor #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] num1,
  input  logic [N-1:0] num2,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] diff,
  output logic         carry_flag,
  output logic         zero_flag,
  output logic         overflow_flag,
  output logic         parity_flag,
  output logic         sign_flag
);
  localparam int CW = $clog2(N);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  logic [1:0] state;
  logic [N-1:0] a, b, r, r_n;
  logic [CW-1:0] cnt;
  logic br, br_n, d_i, a_msb, b_msb, accept, last;
  always_comb begin
    d_i = a[0] ^ b[0] ^ br;
    br_n = (~a[0] & b[0]) | (~(a[0] ^ b[0]) & br);
    r_n = {d_i, r[N-1:1]};
    accept = start && (state == IDLE || state == DONE);
    last = state == RUN && cnt == CW'(N - 1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a <= '0;
      b <= '0;
      r <= '0;
      cnt <= '0;
      br <= 1'b0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      diff <= '0;
      carry_flag <= 1'b0;
      zero_flag <= 1'b0;
      overflow_flag <= 1'b0;
      parity_flag <= 1'b0;
      sign_flag <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        a <= num1;
        b <= num2;
        a_msb <= num1[N-1];
        b_msb <= num2[N-1];
        br <= 1'b0;
        cnt <= '0;
        state <= RUN;
        busy <= 1'b1;
      end else if (state == RUN) begin
        a <= a >> 1;
        b <= b >> 1;
        r <= r_n;
        br <= br_n;
        cnt <= cnt + 1'b1;
        if (last) begin
          state <= DONE;
          busy <= 1'b0;
          done <= 1'b1;
          diff <= r_n;
          carry_flag <= br_n;
          zero_flag <= ~|r_n;
          overflow_flag <= (a_msb != b_msb) && (r_n[N-1] != a_msb);
          parity_flag <= ~^r_n;
          sign_flag <= r_n[N-1];
        end
      end else begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: scoreboard bench, random and directed operations vs arithmetic model
module tb_serial_subtractor;
  localparam int N = 4;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [N-1:0] num1 = '0, num2 = '0;
  logic busy, done, carry_flag, zero_flag, overflow_flag, parity_flag, sign_flag;
  logic [N-1:0] diff;
  int cyc = 0, pass = 0, total = 0;
  logic [N+4:0] eq[$];
  int dq[$];
  logic [N+4:0] held = '0;
  wire [N+4:0] got = {diff, carry_flag, zero_flag, overflow_flag, parity_flag, sign_flag};

  serial_subtractor #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .num1(num1), .num2(num2),
    .busy(busy), .done(done), .diff(diff), .carry_flag(carry_flag),
    .zero_flag(zero_flag), .overflow_flag(overflow_flag),
    .parity_flag(parity_flag), .sign_flag(sign_flag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [N+4:0] model(input logic [N-1:0] x, input logic [N-1:0] y);
    int d = int'(x) - int'(y);
    int sd = int'($signed(x)) - int'($signed(y));
    logic [N-1:0] res = N'(d);
    return {res, x < y, res == 0, sd > (2 ** (N - 1)) - 1 || sd < -(2 ** (N - 1)),
            $countones(res) % 2 == 0, res[N-1]};
  endfunction

  // Monitor: reset clears everything, done pops the scoreboard, otherwise results must hold.
  always @(posedge clk) begin
    logic was_rst;
    logic [N+4:0] e;
    int due;
    was_rst = rst;
    #1;
    if (was_rst) begin
      eq.delete();
      dq.delete();
      held = '0;
      chk("reset_state", {busy, done, got}, '0);
    end else if (done) begin
      if (eq.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        e = eq.pop_front();
        due = dq.pop_front();
        chk("result", got, e);
        chk("latency", cyc, due);
        held = e;
      end
    end else chk("hold", got, held);
  end

  task automatic issue(input logic [N-1:0] x, input logic [N-1:0] y);
    start = 1'b1;
    num1 = x;
    num2 = y;
    eq.push_back(model(x, y));
    dq.push_back(cyc + 1 + N);
    @(negedge clk);
    start = 1'b0;
    chk("busy_accept", busy, 1);
  endtask

  task automatic run_op(input logic [N-1:0] x, input logic [N-1:0] y, input bit junk);
    issue(x, y);
    for (int i = 1; i < N; i++) begin
      if (junk) begin
        start = 1'($urandom_range(0, 1));
        num1 = N'($urandom);
        num2 = N'($urandom);
      end
      @(negedge clk);
      chk("busy_run", busy, 1);
    end
    start = 1'b0;
    @(negedge clk);
    chk("busy_done", busy, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op(4'b0101, 4'b0011, 1'b0);
    @(negedge clk);
    run_op(4'b0011, 4'b0101, 1'b0);
    @(negedge clk);
    run_op(4'b0111, 4'b1111, 1'b0);
    @(negedge clk);
    run_op(4'b0110, 4'b0110, 1'b0);
    run_op(4'b1000, 4'b0001, 1'b0);
    @(negedge clk);
    run_op(4'b1010, 4'b0100, 1'b1);
    @(negedge clk);
    issue(4'b1100, 4'b0011);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_busy", {busy, done}, 0);
    repeat (N + 2) @(negedge clk);
    run_op(4'b1001, 4'b0110, 1'b0);
    for (int i = 0; i < 40; i++) begin
      run_op(N'($urandom), N'($urandom), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    repeat (3) @(negedge clk);
    chk("drain", eq.size(), 0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
